// File: rtl/host_link.sv
// Program loader and output capture for a small CPU: streams an image into program
// memory, releases the CPU, and queues its output. Define HOST_LINK_WATCHDOG_EN for the run watchdog.
module host_link #(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 8,
    parameter int                FIFO_DEPTH     = 16,
    parameter logic [DATA_W-1:0] EXIT_CODE      = '1,
    parameter int                TIMEOUT_CYCLES = 10000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    input  logic [DATA_W-1:0] cpu_out,
    input  logic              cpu_out_on,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              done,
    output logic              timeout,
    output logic              overflow
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("host_link: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              cpu_run_q;
    logic              on_prev_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic in_run, xfer, evt, exit_evt, push_req, push, pop, full, wd_expire;

    assign in_run    = (state_q == ST_RUN);
    assign ld_ready  = (state_q == ST_LOAD);
    assign xfer      = ld_ready && ld_valid;
    // Only the rising edge of the strobe is an event, so a held strobe counts once.
    assign evt       = cpu_out_on && !on_prev_q;
    assign exit_evt  = in_run && evt && (cpu_out == EXIT_CODE);
    assign push_req  = in_run && evt && (cpu_out != EXIT_CODE);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign push      = push_req && (!full || pop);

`ifdef HOST_LINK_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else if (in_run) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_q <= '0;
        end
    end

    assign wd_expire = in_run && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (push_req && full && !pop) overflow_d = 1'b1;

        // A new load wipes the capture queue and status, overriding any pop this cycle.
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    addr_d     = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (addr_q == '1) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (exit_evt) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (wd_expire) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_run_q   <= 1'b0;
            on_prev_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_we_q   <= xfer;
            if (xfer) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= ld_data;
            end
            // Held off for the first RUN cycle so the CPU starts after the final write lands.
            cpu_run_q  <= in_run && (state_d == ST_RUN);
            on_prev_q  <= cpu_out_on;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= cpu_out;
    end

    assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_run   = cpu_run_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_host_link.sv
// Self-checking bench for host_link: randomized loads and CPU output traffic against a queue model.
module tb_host_link;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, start, ld_valid, ld_ready, mem_we, cpu_run;
    logic       cpu_out_on, out_valid, out_ready, done, timeout, overflow;
    logic [7:0] ld_data, mem_addr, mem_wdata, cpu_out, out_data;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         exp_run, exp_done, exp_ovf;

    host_link #(
        .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(DEPTH), .EXIT_CODE(8'hFF), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .cpu_out(cpu_out), .cpu_out_on(cpu_out_on),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .done(done), .timeout(timeout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no summary, want finish");
        $fatal(1, "bench did not finish");
    end

    // Full image load; checks every write beat and the CPU release timing.
    task automatic do_load(input bit gappy, input bit seq);
        logic [7:0] img [256];
        int sent, got, cyc;
        bit prev_x;
        for (int i = 0; i < 256; i++) img[i] = seq ? 8'(i) : 8'($urandom);
        exp_q.delete();
        exp_run = 0; exp_done = 0; exp_ovf = 0;
        start = 1; @(negedge clk); start = 0;
        n_cmp++;
        if ({done, timeout, overflow, out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL load_entry_clear: got %b want 0000", {done, timeout, overflow, out_valid});
        end
        sent = 0; got = 0; cyc = 0; prev_x = 0;
        while (cyc < 2000) begin
            n_cmp++;
            if (mem_we !== prev_x) begin
                n_fail++;
                $display("FAIL load_mem_we: got %b want %b (beat %0d)", mem_we, prev_x, got);
            end
            if (mem_we === 1'b1 && got < 256) begin
                n_cmp++;
                if (mem_addr !== 8'(got) || mem_wdata !== img[got]) begin
                    n_fail++;
                    $display("FAIL load_write: got addr %h data %h want addr %h data %h",
                             mem_addr, mem_wdata, 8'(got), img[got]);
                end
                got++;
            end
            n_cmp++;
            if (ld_ready !== (sent < 256) || cpu_run !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ready_run: got ld_ready %b cpu_run %b want %b 0", ld_ready, cpu_run, sent < 256);
            end
            if (got == 256) break;
            ld_valid = (sent < 256) && (!gappy || $urandom_range(0, 1) == 1);
            if (sent < 256) ld_data = img[sent];
            prev_x = ld_valid;
            if (ld_valid) sent++;
            @(negedge clk); cyc++;
        end
        ld_valid = 0;
        if (cyc >= 2000) begin
            n_cmp++; n_fail++;
            $display("FAIL load_bound: got %0d writes, want 256", got);
        end
        @(negedge clk);
        n_cmp++;
        if (cpu_run !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_release: got cpu_run %b mem_we %b want 1 0", cpu_run, mem_we);
        end
        exp_run = 1;
    endtask

    // One strobe rising edge; rdy is offered only on that first cycle.
    task automatic strobe(input logic [7:0] v, input int hold, input bit rdy);
        bit pop, was_full;
        logic [7:0] tmp;
        cpu_out = v; cpu_out_on = 1; out_ready = rdy;
        pop = rdy && (exp_q.size() > 0);
        was_full = (exp_q.size() >= DEPTH);
        if (pop) tmp = exp_q.pop_front();
        if (exp_run) begin
            if (v == 8'hFF) begin
                exp_run = 0; exp_done = 1;
            end else if (!was_full || pop) begin
                exp_q.push_back(v);
            end else begin
                exp_ovf = 1;
            end
        end
        @(negedge clk); out_ready = 0;
        for (int i = 1; i < hold; i++) @(negedge clk);
        cpu_out_on = 0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL strobe_valid: got %b want %b (value %h)", out_valid, exp_q.size() != 0, v);
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            if (out_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL strobe_head: got %h want %h", out_data, exp_q[0]);
            end
        end
        n_cmp++;
        if ({overflow, done, cpu_run} !== {exp_ovf, exp_done, exp_run}) begin
            n_fail++;
            $display("FAIL strobe_status: got ovf/done/run %b want %b",
                     {overflow, done, cpu_run}, {exp_ovf, exp_done, exp_run});
        end
    endtask

    task automatic drain(input bit rand_rdy);
        int cyc;
        logic [7:0] tmp;
        cyc = 0;
        while (cyc < 200) begin
            n_cmp++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL drain_valid: got %b want %b", out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                if (out_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL drain_data: got %h want %h", out_data, exp_q[0]);
                end
            end
            if (exp_q.size() == 0) break;
            out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_ready) tmp = exp_q.pop_front();
            @(negedge clk); cyc++;
        end
        out_ready = 0;
        if (cyc >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_bound: got %0d entries left, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ld_ready, mem_we, cpu_run, out_valid, done, timeout, overflow} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {ld_ready, mem_we, cpu_run, out_valid, done, timeout, overflow});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, out_data} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 000000", {mem_addr, mem_wdata, out_data});
        end
        reset = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ld_ready !== 1'b0 || cpu_run !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got ld_ready %b cpu_run %b want 0 0", ld_ready, cpu_run);
        end
    endtask

    task automatic test_hello();
        do_load(0, 1);
        start = 1; @(negedge clk); start = 0;
        @(negedge clk);
        n_cmp++;
        if (ld_ready !== 1'b0 || cpu_run !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_run: got ld_ready %b cpu_run %b want 0 1", ld_ready, cpu_run);
        end
        strobe(8'h48, 1, 0);
        strobe(8'h69, 1, 0);
        strobe(8'hFF, 1, 0);
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL hello_timeout: got %b want 0", timeout);
        end
        strobe(8'h33, 1, 0);
        drain(0);
    endtask

    task automatic test_overflow();
        do_load(1, 0);
        for (int v = 1; v <= 5; v++) strobe(8'(v), 1, 0);
        strobe(8'hFF, 1, 0);
        drain(0);
    endtask

    task automatic test_level_strobe();
        do_load(1, 0);
        strobe(8'h41, 10, 0);
        strobe(8'hFF, 1, 0);
        drain(1);
    endtask

    task automatic test_random();
        do_load(1, 0);
        for (int i = 0; i < 12; i++)
            strobe(8'($urandom_range(0, 254)), $urandom_range(1, 2), $urandom_range(0, 1) == 1);
        strobe(8'hFF, 1, 0);
        drain(1);
    endtask

    task automatic test_mid_reset();
        exp_q.delete();
        start = 1; @(negedge clk); start = 0;
        ld_valid = 1;
        for (int i = 0; i < 100; i++) begin
            ld_data = 8'(i);
            @(negedge clk);
        end
        ld_valid = 0;
        reset = 1;
        #1;
        n_cmp++;
        if ({mem_we, ld_ready, cpu_run, out_valid, done, timeout, overflow} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want 0000000",
                     {mem_we, ld_ready, cpu_run, out_valid, done, timeout, overflow});
        end
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_hold: got mem_we %b addr %h want 0 00", mem_we, mem_addr);
        end
        reset = 0;
        @(negedge clk);
        do_load(0, 0);
        strobe(8'hFF, 1, 0);
    endtask

    task automatic test_watchdog();
        int n;
`ifdef HOST_LINK_WATCHDOG_EN
        do_load(1, 0);
        n = 0;
        while (timeout !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        n_cmp++;
        if (n != 49) begin
            n_fail++;
            $display("FAIL wd_expiry: got timeout after %0d cycles want 49", n);
        end
        n_cmp++;
        if (cpu_run !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_state: got cpu_run %b done %b want 0 0", cpu_run, done);
        end
        exp_run = 0;
        do_load(1, 0);
        repeat (48) @(negedge clk);
        strobe(8'hFF, 1, 0);
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_exit_wins: got timeout %b want 0", timeout);
        end
`else
        do_load(1, 0);
        n = 60;
        repeat (n) @(negedge clk);
        n_cmp++;
        if (cpu_run !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL no_wd_run: got cpu_run %b timeout %b want 1 0", cpu_run, timeout);
        end
        strobe(8'hFF, 1, 0);
`endif
    endtask

    initial begin
        reset = 1; start = 0; ld_valid = 0; ld_data = 0;
        cpu_out = 0; cpu_out_on = 0; out_ready = 0;
        test_reset();
        test_hello();
        test_overflow();
        test_level_strobe();
        test_random();
        test_mid_reset();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/host_link.md
HOST_LINK -- requirements
Module: host_link

Interface
REQ-001 Parameter ADDR_W, 8, program memory address width; image length is 2^ADDR_W words.
REQ-002 Parameter DATA_W, 8, width of load words, memory words and CPU output words.
REQ-003 Parameter FIFO_DEPTH, 16, output capture FIFO entries; power of two, >= 2.
REQ-004 Parameter EXIT_CODE, all ones (8'hFF at DATA_W=8), CPU output value that ends the run.
REQ-005 Parameter TIMEOUT_CYCLES, 10000, RUN-state cycle budget (watchdog builds only).
REQ-006 Port clk  in  1  single clock; all state on rising edge.
REQ-007 Port reset  in  1  asynchronous, active-high reset.
REQ-008 Port start  in  1  one-cycle pulse that begins a load.
REQ-009 Ports ld_valid in 1, ld_data in DATA_W, ld_ready out 1  program-image input stream.
REQ-010 Ports mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W  CPU program memory write port.
REQ-011 Port cpu_run  out  1  CPU released when high, held in reset when low.
REQ-012 Ports cpu_out in DATA_W, cpu_out_on in 1  CPU output port and its strobe.
REQ-013 Ports out_valid out 1, out_data out DATA_W, out_ready in 1  captured-output stream.
REQ-014 Ports done out 1, timeout out 1, overflow out 1  sticky status flags.

Function
REQ-015 FSM states IDLE, LOAD, RUN, DONE, TIMEOUT; a start pulse in IDLE, DONE or TIMEOUT moves the FSM to LOAD on the next edge.
REQ-016 On entry to LOAD: load address = 0, FIFO emptied, done/timeout/overflow cleared.
REQ-017 ld_ready is high only in LOAD; a transfer occurs when ld_valid and ld_ready are both high on a rising edge.
REQ-018 Each transfer drives mem_we=1 with mem_addr=load address and mem_wdata=ld_data, registered, for exactly the next cycle; the address then increments.
REQ-019 Transfer at address 2^ADDR_W-1 (wrap point) moves the FSM to RUN; the address wraps to 0; no further ld_ready that cycle.
REQ-020 cpu_run is registered and high only in RUN; first cycle high is the cycle after the final mem_we.
REQ-021 Output event = rising edge of cpu_out_on (registered previous value); level-held strobes count once.
REQ-022 In RUN, an event with cpu_out==EXIT_CODE moves the FSM to DONE and sets done; the value is not pushed.
REQ-023 In RUN, any other event pushes cpu_out into the FIFO; events outside RUN are ignored.
REQ-024 FIFO: out_valid = not empty; out_data = head entry; pop when out_valid && out_ready.
REQ-025 Push while full with no pop: value dropped, overflow set; push+pop same cycle while full: both occur, count unchanged, no overflow.
REQ-026 Push+pop same cycle while empty: out_valid stays low that cycle; entry visible next cycle.
REQ-027 FIFO remains readable in DONE and TIMEOUT until emptied or next start.
REQ-028 start while in LOAD or RUN is ignored.

Reset
REQ-029 reset asserted: FSM=IDLE, addresses 0, FIFO empty, mem_we=0, cpu_run=0, ld_ready=0, out_valid=0, out_data=0, done=timeout=overflow=0, watchdog count 0.
REQ-030 Reset mid-LOAD or mid-RUN abandons the operation immediately; no mem_we after reset asserts.

Configuration
REQ-031 Macro HOST_LINK_WATCHDOG_EN defined: a counter clears on RUN entry, increments each RUN cycle; reaching TIMEOUT_CYCLES without exit moves FSM to TIMEOUT, sets timeout, drops cpu_run.
REQ-032 Macro undefined: no counter logic; TIMEOUT unreachable; timeout tied 0; RUN ends only on EXIT_CODE or reset.
REQ-033 Exit event and timeout expiry on the same cycle: exit wins (DONE, done=1, timeout=0).

Verification
REQ-034 Load 256 bytes i=0..255 with ld_valid held -> mem_we on 256 consecutive cycles, mem_addr=i, mem_wdata=i; cpu_run rises one cycle after last write.
REQ-035 RUN, cpu_out strobes 0x48, 0x69, then 0xFF -> FIFO yields 0x48, 0x69; done=1; cpu_run=0; 0xFF not captured.
REQ-036 FIFO_DEPTH=4, out_ready=0, 5 strobes 1..5 -> FIFO holds 1..4, overflow=1; drain returns 1,2,3,4.
REQ-037 Watchdog build, TIMEOUT_CYCLES=50, no strobes -> TIMEOUT 50 cycles after RUN entry, timeout=1, cpu_run=0; non-watchdog build stays in RUN.
REQ-038 reset pulse after 100 loaded bytes, then start and full reload -> load restarts at address 0; all flags 0 after reset.
REQ-039 cpu_out_on held high 10 cycles with cpu_out=0x41 -> exactly one 0x41 captured.
